// File: rtl/radix3_pkg.sv
// Shared types and constants for the radix-3 butterfly scheduler.
// Holds the FSM state encoding, the complex sample struct, the default word
// width and the out_idx encodings used by the scheduler and its serializer.
package radix3_pkg;

  // IEEE-754 single-precision word width.
  localparam int RADIX3_DW = 32;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WAIT    = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [RADIX3_DW-1:0] re;
    logic [RADIX3_DW-1:0] img;
  } cplx_t;

  // out_idx values: which butterfly output is being presented.
  localparam logic [1:0] IDX_AO = 2'd0;
  localparam logic [1:0] IDX_BO = 2'd1;
  localparam logic [1:0] IDX_CO = 2'd2;

endpackage

// File: rtl/radix3_out_ser.sv
// Output serializer: captures the three butterfly results in one edge and
// presents them one per out_valid/out_ready handshake (ao, bo, co order).
// Ports: cap_i loads results and raises out_valid; done_o pulses on the final
// handshake. Data and index hold stable while out_valid is stalled.
module radix3_out_ser
  import radix3_pkg::*;
#(
  parameter int DW = RADIX3_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap_i,
  input  logic [DW-1:0] ao_re_i,
  input  logic [DW-1:0] ao_img_i,
  input  logic [DW-1:0] bo_re_i,
  input  logic [DW-1:0] bo_img_i,
  input  logic [DW-1:0] co_re_i,
  input  logic [DW-1:0] co_img_i,
  input  logic          out_ready_i,
  output logic          out_valid_o,
  output logic [DW-1:0] out_re_o,
  output logic [DW-1:0] out_img_o,
  output logic [1:0]    out_idx_o,
  output logic          done_o
);

  logic [DW-1:0] res_re_q  [3];
  logic [DW-1:0] res_img_q [3];
  logic [1:0]    oidx_q, oidx_d;
  logic          vld_q, vld_d;
  logic          hs;

  assign hs     = vld_q & out_ready_i;
  assign done_o = hs & (oidx_q == IDX_CO);

  always_comb begin
    oidx_d = oidx_q;
    vld_d  = vld_q;
    if (cap_i) begin
      vld_d  = 1'b1;
      oidx_d = IDX_AO;
    end else if (hs) begin
      if (oidx_q == IDX_CO) begin
        vld_d  = 1'b0;
        oidx_d = IDX_AO;
      end else begin
        oidx_d = oidx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      oidx_q <= IDX_AO;
      for (int i = 0; i < 3; i++) begin
        res_re_q[i]  <= '0;
        res_img_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      oidx_q <= oidx_d;
      if (cap_i) begin
        res_re_q[0]  <= ao_re_i;
        res_img_q[0] <= ao_img_i;
        res_re_q[1]  <= bo_re_i;
        res_img_q[1] <= bo_img_i;
        res_re_q[2]  <= co_re_i;
        res_img_q[2] <= co_img_i;
      end
    end
  end

  // Output mux keyed only by registered state, so it cannot glitch while stalled.
  always_comb begin
    case (oidx_q)
      IDX_BO: begin
        out_re_o  = res_re_q[1];
        out_img_o = res_img_q[1];
      end
      IDX_CO: begin
        out_re_o  = res_re_q[2];
        out_img_o = res_img_q[2];
      end
      default: begin
        out_re_o  = res_re_q[0];
        out_img_o = res_img_q[0];
      end
    endcase
  end

  assign out_valid_o = vld_q;
  assign out_idx_o   = oidx_q;

endmodule

// File: rtl/radix3_bfly_sched.sv
// Radix-3 butterfly scheduler: collects three serial complex samples, drives
// them to an external butterfly, waits BF_LAT clocks, then serializes the
// three results. No arithmetic on samples. Ports: in_* serial input handshake,
// bf_* operand drive, bf_*o results, out_* serial output with index,
// busy (WAIT/DRAIN), frame_cnt (frames completed). Optional feature macro:
// RADIX3_FRAME_CNT_EN enables the 16-bit wrapping frame counter; otherwise
// frame_cnt is tied to 0. BF_LAT legal range is 1..15.
module radix3_bfly_sched
  import radix3_pkg::*;
#(
  parameter int BF_LAT = 4,
  parameter int DW     = RADIX3_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_img,
  output logic [DW-1:0] bf_a_re,
  output logic [DW-1:0] bf_a_img,
  output logic [DW-1:0] bf_b_re,
  output logic [DW-1:0] bf_b_img,
  output logic [DW-1:0] bf_c_re,
  output logic [DW-1:0] bf_c_img,
  input  logic [DW-1:0] bf_ao_re,
  input  logic [DW-1:0] bf_ao_img,
  input  logic [DW-1:0] bf_bo_re,
  input  logic [DW-1:0] bf_bo_img,
  input  logic [DW-1:0] bf_co_re,
  input  logic [DW-1:0] bf_co_img,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_img,
  output logic [1:0]    out_idx,
  output logic          busy,
  output logic [15:0]   frame_cnt
);

  localparam logic [3:0] WCNT_LAST = 4'(BF_LAT - 1);

  state_t        state_q, state_d;
  logic [1:0]    k_q, k_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          ld_a, ld_b, launch, cap, ser_done;
  logic [DW-1:0] slot_a_re_q, slot_a_img_q, slot_b_re_q, slot_b_img_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    wcnt_d   = wcnt_q;
    in_ready = 1'b0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    launch   = 1'b0;
    cap      = 1'b0;
    case (state_q)
      COLLECT: begin
        // Held low during reset so nothing is accepted on a reset edge.
        in_ready = ~rst;
        if (in_valid && !rst) begin
          case (k_q)
            2'd0: begin
              ld_a = 1'b1;
              k_d  = 2'd1;
            end
            2'd1: begin
              ld_b = 1'b1;
              k_d  = 2'd2;
            end
            default: begin
              launch  = 1'b1;
              k_d     = 2'd0;
              wcnt_d  = '0;
              state_d = WAIT;
            end
          endcase
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q + 4'd1;
        if (wcnt_q == WCNT_LAST) begin
          cap     = 1'b1;
          wcnt_d  = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ser_done) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      k_q     <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Third sample goes straight to the operand registers alongside slots a/b,
  // so operands change exactly once per triple and then hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_a_re_q  <= '0;
      slot_a_img_q <= '0;
      slot_b_re_q  <= '0;
      slot_b_img_q <= '0;
      bf_a_re      <= '0;
      bf_a_img     <= '0;
      bf_b_re      <= '0;
      bf_b_img     <= '0;
      bf_c_re      <= '0;
      bf_c_img     <= '0;
    end else begin
      if (ld_a) begin
        slot_a_re_q  <= in_re;
        slot_a_img_q <= in_img;
      end
      if (ld_b) begin
        slot_b_re_q  <= in_re;
        slot_b_img_q <= in_img;
      end
      if (launch) begin
        bf_a_re  <= slot_a_re_q;
        bf_a_img <= slot_a_img_q;
        bf_b_re  <= slot_b_re_q;
        bf_b_img <= slot_b_img_q;
        bf_c_re  <= in_re;
        bf_c_img <= in_img;
      end
    end
  end

  radix3_out_ser #(
    .DW(DW)
  ) u_out_ser (
    .clk         (clk),
    .rst         (rst),
    .cap_i       (cap),
    .ao_re_i     (bf_ao_re),
    .ao_img_i    (bf_ao_img),
    .bo_re_i     (bf_bo_re),
    .bo_img_i    (bf_bo_img),
    .co_re_i     (bf_co_re),
    .co_img_i    (bf_co_img),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_re_o    (out_re),
    .out_img_o   (out_img),
    .out_idx_o   (out_idx),
    .done_o      (ser_done)
  );

  assign busy = (state_q != COLLECT);

`ifdef RADIX3_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (ser_done) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: doc/radix3_bfly_sched.md
RADIX3_BFLY_SCHED -- requirements
Module: radix3_bfly_sched

Interface
REQ-001 SHALL have parameter BF_LAT, default 4: butterfly latency in clocks, legal range 1..15.
REQ-002 SHALL have parameter DW, default 32: IEEE-754 single-precision word width.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): serial complex-sample handshake.
REQ-006 SHALL have ports in_re and in_img, input, DW each: real and imaginary parts of the sample.
REQ-007 SHALL have ports bf_a_re, bf_a_img, bf_b_re, bf_b_img, bf_c_re, bf_c_img, output, DW each: butterfly operand drive.
REQ-008 SHALL have ports bf_ao_re, bf_ao_img, bf_bo_re, bf_bo_img, bf_co_re, bf_co_img, input, DW each: butterfly results.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): serial result handshake.
REQ-010 SHALL have ports out_re and out_img (output, DW each) and out_idx (output, 2): result data and index (0=ao, 1=bo, 2=co).
REQ-011 SHALL have ports busy (output, 1) and frame_cnt (output, 16).

Function
REQ-012 SHALL implement FSM states COLLECT, WAIT and DRAIN.
REQ-013 In COLLECT: in_ready=1; each in_valid&in_ready handshake SHALL store the sample into slot k (0=a, 1=b, 2=c), then k++.
REQ-014 On the handshake with k=2, the registered bf_* operands SHALL update on that edge from slots a, b and the current sample; FSM -> WAIT with wcnt=0, k=0.
REQ-015 bf_* operand outputs SHALL hold stable from that edge until the next triple launches.
REQ-016 In WAIT: in_ready=0; wcnt SHALL increment each edge; on the edge where wcnt==BF_LAT-1, all six bf_*o inputs SHALL be captured into result registers; FSM -> DRAIN, oidx=0.
REQ-017 Timing: out_valid first high after BF_LAT edges following the third-input accept edge.
REQ-018 In DRAIN: out_valid=1, out_idx=oidx, out_re/out_img = captured result[oidx]; out_re, out_img and out_idx SHALL be stable while out_valid&!out_ready.
REQ-019 Each out_valid&out_ready SHALL advance oidx; the handshake at oidx=2 SHALL drop out_valid, increment frame_cnt and return to COLLECT.
REQ-020 in_ready SHALL first reassert the cycle after the third output handshake; input and output handshakes never coincide.
REQ-021 in_valid while in_ready=0 SHALL be ignored; data is not latched.
REQ-022 busy SHALL be 1 in WAIT and DRAIN, and 0 in COLLECT.
REQ-023 frame_cnt SHALL wrap 0xFFFF -> 0x0000.
REQ-024 The block SHALL perform no arithmetic on samples: pass-through and storage only.

Reset
REQ-025 When rst=1 at an edge: FSM=COLLECT, k=0, wcnt=0, oidx=0; out_valid=0; out_re, out_img, out_idx, all bf_* and frame_cnt = 0; in_ready=0 while rst is high.
REQ-026 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-027 Reset in any state, including mid-WAIT or mid-DRAIN, SHALL discard the partial triple and pending results.

Configuration
REQ-028 With macro RADIX3_FRAME_CNT_EN defined, frame_cnt SHALL behave per REQ-019/023.
REQ-029 Without RADIX3_FRAME_CNT_EN, frame_cnt SHALL be constant 0 and no counter register SHALL be synthesized.

Structure
REQ-030 Shared package radix3_pkg SHALL hold: the FSM state typedef, the complex {re,img} struct typedef, the DW default and the out_idx encodings.
REQ-031 The output serializer (result registers, oidx and out handshake) SHALL be sub-module radix3_out_ser.
REQ-032 The butterfly (radix_3_top) SHALL remain external and SHALL NOT be instantiated inside.

Verification (bench butterfly stub: BF_LAT-cycle delay, ao=a, bo=b, co=c)
REQ-033 Reset then idle -> in_ready=1, out_valid=0, busy=0, frame_cnt=0.
REQ-034 Send a=(3f800000,0), b=(40000000,0), c=(40400000,0) back-to-back, out_ready=1 -> out_valid high BF_LAT edges after third accept; outputs re=3f800000/40000000/40400000 with idx 0/1/2 on consecutive cycles; frame_cnt=1.
REQ-035 Hold out_ready=0 for 10 cycles in DRAIN -> out_re=3f800000, out_idx=0 stable; in_ready=0 throughout; in_valid pulses ignored.
REQ-036 Assert rst after the second input, then send a full new triple -> only the new triple is output; frame_cnt=1.
REQ-037 BF_LAT=1 and BF_LAT=15 builds -> first out_valid exactly 1 and 15 edges after third accept.
REQ-038 Preload frame_cnt=0xFFFF, complete one frame -> 0x0000; without RADIX3_FRAME_CNT_EN, frame_cnt=0 always.
